// File: rtl/imager_multi.sv
// ----------------------------------------------------------------------------
// imager_multi
//
// Synthetic multi-lane image source. Produces PIXELS_PER_CLK pixels per clock
// with fv/lv framing, programmable horizontal/vertical blanking and either
// continuous or triggered single-shot frames. Used as the stand-in sensor in
// front of the capture/ISP pipeline.
//
// Ports
//   clk               sole clock
//   reset_n           asynchronous active-low reset
//   enable            0 forces IDLE and clears all outputs on the next clock
//   continuous        1 = back-to-back frames, 0 = one frame per trigger
//   trigger           single-cycle frame request, honoured only in IDLE
//   mode              pattern select (0 noise .. 7 zero)
//   bayer_*           constant colour values for the bayer pattern
//   num_active_rows   active rows per frame
//   num_virtual_rows  blanking rows per frame
//   num_active_cols   active pixels per row (multiple of PIXELS_PER_CLK)
//   num_virtual_cols  blanking clocks per row
//   noise_seed        nonzero: LFSR reloaded at every frame start
//   dat               packed pixels, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   fv, lv            frame valid, line valid
//   img_start         pulse on the first clock of a frame
//   row_start         pulse on the first clock of each row
//   frame_done        pulse on the last clock of a frame
//   busy              high while a frame is being produced
//   frame_count       number of completed frames (wraps at 16 bits)
//
// All outputs are registered and lag the position counters by one clock.
// ----------------------------------------------------------------------------
module imager_multi #(
    parameter int DATA_WIDTH     = 10,
    parameter int PIXELS_PER_CLK = 2,
    parameter int NUM_ROWS_WIDTH = 12,
    parameter int NUM_COLS_WIDTH = 12
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 enable,
    input  logic                                 continuous,
    input  logic                                 trigger,
    input  logic [2:0]                           mode,
    input  logic [DATA_WIDTH-1:0]                bayer_r,
    input  logic [DATA_WIDTH-1:0]                bayer_gr,
    input  logic [DATA_WIDTH-1:0]                bayer_gb,
    input  logic [DATA_WIDTH-1:0]                bayer_b,
    input  logic [NUM_ROWS_WIDTH-1:0]            num_active_rows,
    input  logic [NUM_ROWS_WIDTH-1:0]            num_virtual_rows,
    input  logic [NUM_COLS_WIDTH-1:0]            num_active_cols,
    input  logic [NUM_COLS_WIDTH-1:0]            num_virtual_cols,
    input  logic [31:0]                          noise_seed,
    output logic [DATA_WIDTH*PIXELS_PER_CLK-1:0] dat,
    output logic                                 fv,
    output logic                                 lv,
    output logic                                 img_start,
    output logic                                 row_start,
    output logic                                 frame_done,
    output logic                                 busy,
    output logic [15:0]                          frame_count
);

    // Lane count is restricted to powers of two so the column divide is a shift.
    localparam int LANE_SHIFT = (PIXELS_PER_CLK == 4) ? 2 :
                                (PIXELS_PER_CLK == 2) ? 1 : 0;
    // Position arithmetic is one bit wider than the configuration fields so
    // active+virtual sums cannot overflow.
    localparam int CW = NUM_COLS_WIDTH + 1;
    localparam int RW = NUM_ROWS_WIDTH + 1;
    localparam int PW = DATA_WIDTH * PIXELS_PER_CLK;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_start;        // a new frame begins on the next clock

    // Per-frame configuration shadow
    logic [2:0]                r_mode;
    logic [DATA_WIDTH-1:0]     r_bay_r;
    logic [DATA_WIDTH-1:0]     r_bay_gr;
    logic [DATA_WIDTH-1:0]     r_bay_gb;
    logic [DATA_WIDTH-1:0]     r_bay_b;
    logic [NUM_ROWS_WIDTH-1:0] r_nar;
    logic [NUM_ROWS_WIDTH-1:0] r_nvr;
    logic [NUM_COLS_WIDTH-1:0] r_nac;
    logic [NUM_COLS_WIDTH-1:0] r_nvc;

    // Position counters and pattern state
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [31:0]   r_pix_cnt;
    logic [31:0]   r_lfsr;

    // Output registers
    logic [PW-1:0] r_dat;
    logic          r_fv;
    logic          r_lv;
    logic          r_img_start;
    logic          r_row_start;
    logic          r_frame_done;
    logic          r_busy;
    logic [15:0]   r_frame_count;

    // ------------------------------------------------------------------
    // Frame geometry derived from the shadowed configuration
    // ------------------------------------------------------------------
    logic [CW-1:0] w_acols;
    logic [CW-1:0] w_hfp;
    logic [CW-1:0] w_hend;
    logic [CW-1:0] w_tot_cols_raw;
    logic [CW-1:0] w_tot_cols;
    logic [RW-1:0] w_vfp;
    logic [RW-1:0] w_vend;
    logic [RW-1:0] w_tot_rows_raw;
    logic [RW-1:0] w_tot_rows;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_in_frame;
    logic          w_last;
    logic          w_fv;
    logic          w_lv;

    assign w_acols        = CW'(r_nac >> LANE_SHIFT);
    assign w_hfp          = CW'(r_nvc >> 1);
    assign w_vfp          = RW'(r_nvr >> 1);
    assign w_hend         = w_hfp + w_acols;
    assign w_vend         = w_vfp + RW'(r_nar);
    assign w_tot_cols_raw = w_acols + CW'(r_nvc);
    assign w_tot_rows_raw = RW'(r_nar) + RW'(r_nvr);
    // A zero-length dimension still occupies one position so the frame ends.
    assign w_tot_cols     = (w_tot_cols_raw == '0) ? CW'(1) : w_tot_cols_raw;
    assign w_tot_rows     = (w_tot_rows_raw == '0) ? RW'(1) : w_tot_rows_raw;

    assign w_col_last = (r_col == w_tot_cols - CW'(1));
    assign w_row_last = (r_row == w_tot_rows - RW'(1));
    assign w_in_frame = (r_state == ST_FRAME) && enable;
    assign w_last     = w_in_frame && w_col_last && w_row_last;

    assign w_fv = (r_row >= w_vfp) && (r_row < w_vend);
    assign w_lv = w_fv && (r_col >= w_hfp) && (r_col < w_hend);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A trigger coinciding with the frame_done output is ignored;
                // the FSM is already back in IDLE at that point.
                if (enable && (continuous || (trigger && !r_frame_done))) begin
                    w_state_next = ST_FRAME;
                    w_start      = 1'b1;
                end
            end
            ST_FRAME: begin
                if (!enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    if (continuous) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Configuration shadow: captured only when a frame starts
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= '0;
            r_bay_r  <= '0;
            r_bay_gr <= '0;
            r_bay_gb <= '0;
            r_bay_b  <= '0;
            r_nar    <= '0;
            r_nvr    <= '0;
            r_nac    <= '0;
            r_nvc    <= '0;
        end else if (w_start) begin
            r_mode   <= mode;
            r_bay_r  <= bayer_r;
            r_bay_gr <= bayer_gr;
            r_bay_gb <= bayer_gb;
            r_bay_b  <= bayer_b;
            r_nar    <= num_active_rows;
            r_nvr    <= num_virtual_rows;
            r_nac    <= num_active_cols;
            r_nvc    <= num_virtual_cols;
        end
    end

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_frame && !w_start) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end else begin
            // IDLE, disabled or frame wrap: the next frame starts at row 0, col 0.
            r_col <= '0;
            r_row <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Noise LFSR: PIXELS_PER_CLK steps unrolled per clock
    // ------------------------------------------------------------------
    logic [31:0] w_lfsr_steps [0:PIXELS_PER_CLK];

    assign w_lfsr_steps[0] = r_lfsr;

    generate
        for (genvar gi = 0; gi < PIXELS_PER_CLK; gi++) begin : g_lfsr
            assign w_lfsr_steps[gi+1] = {w_lfsr_steps[gi][30:0],
                                         ~(w_lfsr_steps[gi][31] ^ w_lfsr_steps[gi][21] ^
                                           w_lfsr_steps[gi][1]  ^ w_lfsr_steps[gi][0])};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr    <= 32'd1;
            r_pix_cnt <= '0;
        end else if (w_start) begin
            r_pix_cnt <= '0;
            // A zero seed lets the sequence run on across frames.
            if (noise_seed != 32'd0) begin
                r_lfsr <= noise_seed;
            end
        end else if (w_in_frame && w_lv) begin
            r_pix_cnt <= r_pix_cnt + 32'(PIXELS_PER_CLK);
            r_lfsr    <= w_lfsr_steps[PIXELS_PER_CLK];
        end
    end

    // ------------------------------------------------------------------
    // Per-lane pattern generation
    // ------------------------------------------------------------------
    logic [31:0] w_y;
    logic [PW-1:0] w_pix;

    // Only meaningful while lv is high; the underflow outside is masked.
    assign w_y = 32'(r_row - w_vfp);

    generate
        for (genvar gi = 0; gi < PIXELS_PER_CLK; gi++) begin : g_lane
            logic [31:0]           w_x;
            logic [31:0]           w_xy;
            logic [31:0]           w_pc;
            logic [DATA_WIDTH-1:0] w_lane;

            assign w_x  = (32'(r_col - w_hfp) << LANE_SHIFT) + 32'(gi);
            assign w_xy = w_x + w_y;
            assign w_pc = r_pix_cnt + 32'(gi);

            always_comb begin
                w_lane = '0;
                case (r_mode)
                    3'd0: w_lane = w_lfsr_steps[gi+1][DATA_WIDTH-1:0];
                    3'd1: w_lane = DATA_WIDTH'(w_y);
                    3'd2: w_lane = DATA_WIDTH'(w_x);
                    3'd3: w_lane = DATA_WIDTH'(w_xy);
                    3'd4: w_lane = DATA_WIDTH'(r_frame_count);
                    3'd5: w_lane = DATA_WIDTH'(w_pc);
                    3'd6: begin
                        if (!w_y[0]) begin
                            w_lane = w_x[0] ? r_bay_gr : r_bay_r;
                        end else begin
                            w_lane = w_x[0] ? r_bay_b : r_bay_gb;
                        end
                    end
                    default: w_lane = '0;
                endcase
            end

            assign w_pix[gi*DATA_WIDTH +: DATA_WIDTH] = w_lane;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dat         <= '0;
            r_fv          <= 1'b0;
            r_lv          <= 1'b0;
            r_img_start   <= 1'b0;
            r_row_start   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
        end else if (w_in_frame) begin
            r_dat        <= w_lv ? w_pix : '0;
            r_fv         <= w_fv;
            r_lv         <= w_lv;
            r_img_start  <= (r_row == '0) && (r_col == '0);
            r_row_start  <= (r_col == '0);
            r_frame_done <= w_last;
            r_busy       <= 1'b1;
            // Counts in step with the frame_done pulse.
            if (w_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end else begin
            r_dat        <= '0;
            r_fv         <= 1'b0;
            r_lv         <= 1'b0;
            r_img_start  <= 1'b0;
            r_row_start  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end
    end

    assign dat         = r_dat;
    assign fv          = r_fv;
    assign lv          = r_lv;
    assign img_start   = r_img_start;
    assign row_start   = r_row_start;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;
    assign frame_count = r_frame_count;

endmodule

// File: tb/tb_imager_multi.sv
module tb_imager_multi;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        continuous;
    logic        trigger;
    logic [2:0]  mode;
    logic [9:0]  bayer_r, bayer_gr, bayer_gb, bayer_b;
    logic [11:0] num_active_rows, num_virtual_rows;
    logic [11:0] num_active_cols, num_virtual_cols;
    logic [31:0] noise_seed;

    // two-lane instance
    logic [19:0] dat;
    logic        fv, lv, img_start, row_start, frame_done, busy;
    logic [15:0] frame_count;

    // four-lane instance
    logic [39:0] dat_4;
    logic        fv_4, lv_4, img_start_4, row_start_4, frame_done_4, busy_4;
    logic [15:0] frame_count_4;

    int n_checks = 0;
    int n_errors = 0;

    int          len, nlv, nfv, j;
    logic [31:0] m, s1, s2;
    logic [63:0] e;

    always #5 clk = ~clk;

    imager_multi #(.DATA_WIDTH(10), .PIXELS_PER_CLK(2), .NUM_ROWS_WIDTH(12), .NUM_COLS_WIDTH(12)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .continuous(continuous), .trigger(trigger),
        .mode(mode), .bayer_r(bayer_r), .bayer_gr(bayer_gr), .bayer_gb(bayer_gb), .bayer_b(bayer_b),
        .num_active_rows(num_active_rows), .num_virtual_rows(num_virtual_rows),
        .num_active_cols(num_active_cols), .num_virtual_cols(num_virtual_cols),
        .noise_seed(noise_seed), .dat(dat), .fv(fv), .lv(lv), .img_start(img_start),
        .row_start(row_start), .frame_done(frame_done), .busy(busy), .frame_count(frame_count)
    );

    imager_multi #(.DATA_WIDTH(10), .PIXELS_PER_CLK(4), .NUM_ROWS_WIDTH(12), .NUM_COLS_WIDTH(12)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .continuous(continuous), .trigger(trigger),
        .mode(mode), .bayer_r(bayer_r), .bayer_gr(bayer_gr), .bayer_gb(bayer_gb), .bayer_b(bayer_b),
        .num_active_rows(num_active_rows), .num_virtual_rows(num_virtual_rows),
        .num_active_cols(num_active_cols), .num_virtual_cols(num_virtual_cols),
        .noise_seed(noise_seed), .dat(dat_4), .fv(fv_4), .lv(lv_4), .img_start(img_start_4),
        .row_start(row_start_4), .frame_done(frame_done_4), .busy(busy_4), .frame_count(frame_count_4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable     = 1'b0;
        continuous = 1'b0;
        trigger    = 1'b0;
        noise_seed = 32'd0;
        reset_n    = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic set_cfg(input int nar, input int nvr, input int nac, input int nvc, input int md);
        num_active_rows  = 12'(nar);
        num_virtual_rows = 12'(nvr);
        num_active_cols  = 12'(nac);
        num_virtual_cols = 12'(nvc);
        mode             = 3'(md);
    endtask

    // Counts one frame on the two-lane instance, starting from the current
    // sample (its first clock) up to and including the frame_done clock.
    task automatic measure_frame(input string tag, output int flen, output int flv, output int ffv);
        flen = 0;
        flv  = 0;
        ffv  = 0;
        for (int k = 0; k < 4000; k++) begin
            if (lv) flv++;
            if (fv) ffv++;
            flen++;
            if (frame_done) break;
            step();
        end
        if (!frame_done) check_eq({tag, "_timeout"}, 64'(0), 64'(1));
        $display("%s: frame of %0d clocks, %0d lv clocks, %0d fv clocks", tag, flen, flv, ffv);
    endtask

    // Geometry of the 4x8 active / 2x4 virtual frame on two lanes:
    // 8 clocks per row, active rows 1..4, active cols 2..5.
    function automatic bit geo_lv(input int i);
        int r, c;
        r = i / 8;
        c = i % 8;
        return (r >= 1) && (r < 5) && (c >= 2) && (c < 6);
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bayer_r = 10'h011; bayer_gr = 10'h022; bayer_gb = 10'h033; bayer_b = 10'h044;
        set_cfg(4, 2, 8, 4, 2);

        // ---------------- reset state ----------------
        do_reset();
        check_eq("rst_dat", 64'(dat), 64'(0));
        check_eq("rst_fv", 64'(fv), 64'(0));
        check_eq("rst_lv", 64'(lv), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_fcnt", 64'(frame_count), 64'(0));
        check_eq("rst_img", 64'(img_start), 64'(0));
        check_eq("rst_done", 64'(frame_done), 64'(0));
        $display("reset: outputs idle");

        // ---------------- column pattern, continuous ----------------
        continuous = 1'b1;
        enable     = 1'b1;
        step();
        check_eq("col_lat_img", 64'(img_start), 64'(0));
        check_eq("col_lat_busy", 64'(busy), 64'(0));
        step();
        check_eq("col_busy", 64'(busy), 64'(1));
        check_eq("col_fcnt0", 64'(frame_count), 64'(0));
        for (int i = 0; i < 48; i++) begin
            int c;
            c = i % 8;
            e = '0;
            if (geo_lv(i)) e = 64'({10'(2 * (c - 2) + 1), 10'(2 * (c - 2))});
            check_eq("col_lv", 64'(lv), 64'(geo_lv(i)));
            check_eq("col_fv", 64'(fv), 64'((i / 8 >= 1) && (i / 8 < 5)));
            check_eq("col_dat", 64'(dat), e);
            check_eq("col_img", 64'(img_start), 64'(i == 0));
            check_eq("col_rowst", 64'(row_start), 64'(c == 0));
            check_eq("col_done", 64'(frame_done), 64'(i == 47));
            if (i == 47) check_eq("col_fcnt1", 64'(frame_count), 64'(1));
            else step();
        end
        $display("column frame 0 checked");
        step();
        check_eq("cont_nogap_img", 64'(img_start), 64'(1));
        check_eq("cont_fcnt", 64'(frame_count), 64'(1));

        // ---------------- mid-frame column change ----------------
        num_active_cols = 12'd4;
        measure_frame("shadow_f1", len, nlv, nfv);
        check_eq("shadow_f1_len", 64'(len), 64'(48));
        check_eq("shadow_f1_lv", 64'(nlv), 64'(16));
        step();
        check_eq("shadow_f2_img", 64'(img_start), 64'(1));
        measure_frame("shadow_f2", len, nlv, nfv);
        check_eq("shadow_f2_len", 64'(len), 64'(36));
        check_eq("shadow_f2_lv", 64'(nlv), 64'(8));

        // ---------------- four lanes, pixel counter ----------------
        do_reset();
        set_cfg(4, 2, 8, 6, 5);
        continuous = 1'b1;
        enable     = 1'b1;
        step();
        step();
        for (int f = 0; f < 2; f++) begin
            j = 0;
            for (int i = 0; i < 48; i++) begin
                if (i == 0) begin
                    check_eq("pc4_img", 64'(img_start_4), 64'(1));
                    check_eq("pc4_fcnt_start", 64'(frame_count_4), 64'(f));
                end
                check_eq("pc4_done", 64'(frame_done_4), 64'(i == 47));
                if (lv_4) begin
                    e = 64'({10'(4 * j + 3), 10'(4 * j + 2), 10'(4 * j + 1), 10'(4 * j)});
                    check_eq("pc4_dat", 64'(dat_4), e);
                    j++;
                end
                if (i == 47) check_eq("pc4_fcnt_end", 64'(frame_count_4), 64'(f + 1));
                step();
            end
            check_eq("pc4_lv_clocks", 64'(j), 64'(8));
            $display("four-lane frame %0d: %0d lv clocks", f, j);
        end
        check_eq("pc4_img_48", 64'(img_start_4), 64'(1));

        // ---------------- single shot ----------------
        do_reset();
        set_cfg(4, 2, 8, 4, 2);
        enable  = 1'b1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        check_eq("ss_img", 64'(img_start), 64'(1));
        check_eq("ss_busy", 64'(busy), 64'(1));
        for (int i = 1; i < 48; i++) begin
            step();
            if (i == 10) trigger = 1'b1;
            if (i == 11) trigger = 1'b0;
        end
        check_eq("ss_done", 64'(frame_done), 64'(1));
        check_eq("ss_done_busy", 64'(busy), 64'(1));
        trigger = 1'b1;                 // coincides with frame_done: ignored
        step();
        trigger = 1'b0;
        check_eq("ss_busy_drop", 64'(busy), 64'(0));
        j = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (busy || img_start) j++;
        end
        check_eq("ss_no_restart", 64'(j), 64'(0));
        $display("single shot: one frame, dropped triggers ignored");
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step();
        check_eq("ss2_img", 64'(img_start), 64'(1));
        for (int i = 1; i < 48; i++) step();
        check_eq("ss2_done", 64'(frame_done), 64'(1));
        step();
        check_eq("ss2_busy_drop", 64'(busy), 64'(0));
        trigger = 1'b1;                 // one cycle after frame_done: honoured
        step();
        trigger = 1'b0;
        check_eq("ss2_gap_img", 64'(img_start), 64'(0));
        step();
        check_eq("ss3_img", 64'(img_start), 64'(1));
        check_eq("ss3_busy", 64'(busy), 64'(1));

        // ---------------- noise, seeded and unseeded ----------------
        for (int sd = 0; sd < 2; sd++) begin
            do_reset();
            set_cfg(4, 2, 8, 4, 0);
            noise_seed = (sd == 0) ? 32'h1234_5678 : 32'd0;
            continuous = 1'b1;
            enable     = 1'b1;
            m = 32'd1;
            step();
            step();
            for (int f = 0; f < 2; f++) begin
                if (noise_seed != 32'd0) m = noise_seed;
                for (int i = 0; i < 48; i++) begin
                    e = '0;
                    if (geo_lv(i)) begin
                        s1 = lfsr_next(m);
                        s2 = lfsr_next(s1);
                        m  = s2;
                        e  = 64'({s2[9:0], s1[9:0]});
                    end
                    check_eq((sd == 0) ? "noise_seed_dat" : "noise_free_dat", 64'(dat), e);
                    step();
                end
                $display("noise seed 0x%08h frame %0d checked", noise_seed, f);
            end
        end

        // ---------------- enable dropped mid-frame ----------------
        do_reset();
        set_cfg(4, 2, 8, 4, 1);
        continuous = 1'b1;
        enable     = 1'b1;
        step();
        step();
        for (int i = 1; i <= 19; i++) step();
        check_eq("en_row2_lv", 64'(lv), 64'(1));
        check_eq("en_row2_dat", 64'(dat), 64'({10'd1, 10'd1}));
        enable = 1'b0;
        step();
        check_eq("en_off_dat", 64'(dat), 64'(0));
        check_eq("en_off_lv", 64'(lv), 64'(0));
        check_eq("en_off_fv", 64'(fv), 64'(0));
        check_eq("en_off_busy", 64'(busy), 64'(0));
        check_eq("en_off_fcnt", 64'(frame_count), 64'(0));
        enable = 1'b1;
        step();
        check_eq("en_on_wait", 64'(img_start), 64'(0));
        step();
        check_eq("en_on_img", 64'(img_start), 64'(1));
        for (int i = 1; i <= 7; i++) step();
        check_eq("en_on_fv_row0", 64'(fv), 64'(0));
        step();
        check_eq("en_on_fv_row1", 64'(fv), 64'(1));
        for (int i = 9; i <= 18; i++) step();
        check_eq("en_on_dat_y1", 64'(dat), 64'({10'd1, 10'd1}));
        $display("enable drop: cleared and restarted at row 0");

        // ---------------- bayer ----------------
        do_reset();
        set_cfg(4, 2, 8, 4, 6);
        continuous = 1'b1;
        enable     = 1'b1;
        step();
        step();
        for (int i = 1; i <= 10; i++) step();
        check_eq("bayer_y0", 64'(dat), 64'({bayer_gr, bayer_r}));
        for (int i = 11; i <= 18; i++) step();
        check_eq("bayer_y1", 64'(dat), 64'({bayer_b, bayer_gb}));
        $display("bayer rows checked");

        // ---------------- degenerate sizes ----------------
        do_reset();
        set_cfg(0, 2, 8, 4, 2);
        continuous = 1'b1;
        enable     = 1'b1;
        step();
        step();
        check_eq("deg_img", 64'(img_start), 64'(1));
        measure_frame("deg_rows0", len, nlv, nfv);
        check_eq("deg_len", 64'(len), 64'(16));
        check_eq("deg_lv", 64'(nlv), 64'(0));
        check_eq("deg_fv", 64'(nfv), 64'(0));

        do_reset();
        set_cfg(0, 0, 0, 0, 2);
        continuous = 1'b1;
        enable     = 1'b1;
        step();
        step();
        check_eq("zero_img", 64'(img_start), 64'(1));
        check_eq("zero_done", 64'(frame_done), 64'(1));
        check_eq("zero_fcnt1", 64'(frame_count), 64'(1));
        step();
        check_eq("zero_img2", 64'(img_start), 64'(1));
        check_eq("zero_fcnt2", 64'(frame_count), 64'(2));
        $display("degenerate frames checked");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imager_multi.md
# imager_multi

Parametrised test-pattern image source. Emits PIXELS_PER_CLK pixels per clock on a packed data bus, with fv/lv framing, programmable blanking, and continuous or single-shot (triggered) frame modes. Sits in the same place in sim and FPGA benches as the single-pixel imager model: the synthetic sensor driving the capture/ISP pipeline. It adds multi-lane output, frame triggering, a frame-done pulse and a per-frame configuration shadow.

## Interface
- DATA_WIDTH, 10: bits per pixel.
- PIXELS_PER_CLK, 2: lanes per clock; legal values are 1, 2 and 4.
- NUM_ROWS_WIDTH, 12: width of the row configuration fields.
- NUM_COLS_WIDTH, 12: width of the column configuration fields.

- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  0 forces IDLE immediately and clears all outputs.
- continuous  in  1  1 = back-to-back frames; 0 = one frame per trigger.
- trigger  in  1  single-cycle request to start a frame; only honoured in IDLE.
- mode  in  3  pattern select:
  - 0 noise
  - 1 row
  - 2 column
  - 3 row+column
  - 4 frame_count
  - 5 pixel counter
  - 6 bayer
  - 7 zero
- bayer_r, bayer_gr, bayer_gb, bayer_b  in  DATA_WIDTH each  constant values for mode 6.
- num_active_rows  in  NUM_ROWS_WIDTH  active rows.
- num_virtual_rows  in  NUM_ROWS_WIDTH  blanking rows.
- num_active_cols  in  NUM_COLS_WIDTH  active pixels per row; must be a multiple of PIXELS_PER_CLK.
- num_virtual_cols  in  NUM_COLS_WIDTH  blanking clocks per row.
- noise_seed  in  32  nonzero = LFSR reloaded at every frame start.
- dat  out  DATA_WIDTH*PIXELS_PER_CLK  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 is the leftmost pixel.
- fv, lv  out  1  frame valid, line valid.
- img_start  out  1  pulse on the frame's first clock.
- row_start  out  1  pulse on each row's first clock.
- frame_done  out  1  pulse on the frame's last clock.
- busy  out  1  high while in FRAME.
- frame_count  out  16  number of completed frames.

## Operation
- FSM states are IDLE and FRAME.
  - IDLE→FRAME when enable && (continuous || trigger).
  - FRAME→FRAME at the end of a frame when continuous=1.
  - FRAME→IDLE at the end of a frame when continuous=0, or any cycle with enable=0.
- Configuration shadow: all num_* inputs, mode and the bayer values are sampled on IDLE→FRAME and at each frame wrap. Changes mid-frame take effect on the next frame.
- Counters are col (clocks) and row.
  - acols = num_active_cols/PIXELS_PER_CLK; total row length = acols + num_virtual_cols clocks.
  - total frame height = num_active_rows + num_virtual_rows rows.
  - All sums are computed one bit wider than the field.
- Front porches: hfp = num_virtual_cols>>1; vfp = num_virtual_rows>>1.
- Framing:
  - lv = row in [vfp, vfp+num_active_rows) && col in [hfp, hfp+acols).
  - fv = row in [vfp, vfp+num_active_rows).
- Active coordinates:
  - y = row − vfp.
  - Lane k: x = (col − hfp)*PIXELS_PER_CLK + k.
- Pattern per lane, truncated to DATA_WIDTH:
  - 1: y.
  - 2: x.
  - 3: x+y.
  - 4: frame_count.
  - 5: pixel counter + k. The counter advances by PIXELS_PER_CLK per lv clock and clears at frame start.
  - 6 (bayer): y even → x even = r, x odd = gr; y odd → x even = gb, x odd = b.
  - 0 (noise): 32-bit LFSR, feedback xnor of bits 31, 21, 1, 0.
    - Advances PIXELS_PER_CLK steps per lv clock.
    - Lane k = low DATA_WIDTH bits after k+1 steps.
    - Reloaded with noise_seed at frame start if noise_seed≠0; otherwise it continues from the previous frame.
- dat = 0 whenever lv=0.
- frame_count increments on frame_done and wraps at 16 bits.
- Degenerate configurations:
  - num_active_rows=0 or num_active_cols=0: the frame still runs its blanking with fv/lv low, and frame_done still pulses.
  - Total rows of 0 or total cols of 0 are treated as 1.

## Timing
- Every output is registered. Outputs lag the counters by exactly one clock, and all outputs are mutually aligned.
- Reset value of every output is 0, including frame_count and busy. Internal state resets to IDLE, counters 0, LFSR 1.
- The first clock of FRAME has row=col=0, so img_start and row_start are high on the following clock.
- frame_done is high in the output cycle that corresponds to the frame's last position (row, col).
- Continuous mode: the next frame's img_start immediately follows frame_done, with zero gap clocks.
- Single-shot mode: busy drops in the cycle after frame_done.
  - A trigger in the same cycle as frame_done is ignored.
  - A trigger one cycle later starts a new frame.
- Triggers arriving in FRAME are dropped, not queued.
- enable low mid-frame: next cycle all outputs are 0, counters are 0 and the FSM is in IDLE. frame_count holds its value.
- reset_n asserted mid-frame: all outputs go to 0 asynchronously.

## Test plan
- PIXELS_PER_CLK=2, mode 2, continuous, active 4×8, virtual 2 rows and 4 cols → 4 lv clocks per row, dat = {x+1, x} = {1,0},{3,2},{5,4},{7,6}; 8 clocks per row; 48 clocks per frame.
- PIXELS_PER_CLK=4, mode 5, two frames → pixel values 0..31 per frame with no gaps; frame_count 0→1→2; img_start and frame_done exactly 48 clocks apart.
- Single-shot: trigger, then a second trigger mid-frame → exactly one frame; busy low after frame_done; a trigger one cycle after frame_done starts a frame.
- Change num_active_cols from 8 to 4 mid-frame → current frame keeps 8 columns; the next frame has 4.
- mode 0, noise_seed=0x1234_5678 → two consecutive frames are bit-identical; with seed 0 the frames differ.
- enable dropped at row 2 → all outputs 0 the next cycle; re-enable → img_start, with the first row at row 0.
